// File: rtl/event_encoder_16x4.sv
// rtl/event_encoder_16x4.sv - sequential 16-to-4 event encoder with pending register and valid/ready output
// Optional feature: define ROUND_ROBIN_EN for rotating-priority selection (default: fixed, bit 0 highest).
module event_encoder_16x4 #(
    parameter int SIZE_IN  = 16,
    parameter int SIZE_OUT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE_IN-1:0]  req,
    input  logic                ready,
    output logic [SIZE_OUT-1:0] out,
    output logic                valid,
    output logic [SIZE_IN-1:0]  pend
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SIZE_IN-1:0]  pend_q;
    logic [SIZE_IN-1:0]  clr;
    logic [SIZE_OUT-1:0] out_q;
    logic [SIZE_OUT-1:0] out_next;
    logic [SIZE_OUT-1:0] sel;
    logic                any_pend;
    logic                xfer;

    assign xfer     = (state == HOLD) && ready;
    assign any_pend = |pend_q;

    // Only the code being transferred is cleared; a simultaneous req for it re-sets the bit.
    always_comb begin
        clr = '0;
        if (xfer) begin
            clr[out_q] = 1'b1;
        end
    end

`ifdef ROUND_ROBIN_EN
    logic [SIZE_OUT-1:0] last;
    logic [SIZE_OUT-1:0] idx;
    logic                found;

    // Search starts just past the last transferred code; k = SIZE_IN wraps back onto last itself.
    always_comb begin
        sel   = last;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= SIZE_IN; k++) begin
            idx = last + SIZE_OUT'(k);
            if (!found && pend_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= '1;
        end else if (xfer) begin
            last <= out_q;
        end
    end
`else
    // Scanning from the top down leaves the lowest set index as the winner.
    always_comb begin
        sel = '0;
        for (int i = SIZE_IN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel = SIZE_OUT'(i);
            end
        end
    end
`endif

    always_comb begin
        state_next = state;
        out_next   = out_q;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    out_next   = sel;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            out_q  <= '0;
            pend_q <= '0;
        end else begin
            state  <= state_next;
            out_q  <= out_next;
            pend_q <= (pend_q & ~clr) | req;
        end
    end

    assign out   = out_q;
    assign valid = (state == HOLD);
    assign pend  = pend_q;

endmodule

// File: tb/tb_event_encoder_16x4.sv
// tb/tb_event_encoder_16x4.sv - scoreboard bench for event_encoder_16x4 (fixed priority or ROUND_ROBIN_EN)
module tb_event_encoder_16x4;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        ready;
    logic [3:0]  out;
    logic        valid;
    logic [15:0] pend;

    int          n_checks;
    int          n_pass;
    int          xfer_cnt;
    logic [3:0]  exp_q[$];

    event_encoder_16x4 #(.SIZE_IN(16), .SIZE_OUT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .out   (out),
        .valid (valid),
        .pend  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        ready = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        tick();
    endtask

    task automatic wait_empty(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            tick();
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Transfers are observed half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                check("extra_xfer", {28'd0, out}, 32'hFFFF_FFFF);
            end else begin
                check("code", {28'd0, out}, {28'd0, exp_q.pop_front()});
            end
            xfer_cnt++;
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        xfer_cnt = 0;
        rst      = 1'b1;
        req      = '0;
        ready    = 1'b0;
        #12;
        check("rst_valid", valid, 0);
        check("rst_out", out, 0);
        check("rst_pend", pend, 0);
        rst = 1'b0;
        tick();

        // Single event: two-edge latency from req to valid
        req   = 16'h0100;
        ready = 1'b1;
        exp_q.push_back(4'd8);
        tick();
        req = '0;
        check("single_pend", pend, 16'h0100);
        check("single_valid0", valid, 0);
        tick();
        check("single_valid1", valid, 1);
        check("single_out", out, 8);
        tick();
        check("single_pend_clr", pend, 0);
        check("single_valid_clr", valid, 0);
        check("single_out_kept", out, 8);

        // Asynchronous reset mid-cycle with all requests high
        ready = 1'b0;
        req   = 16'hFFFF;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("areset_pend", pend, 0);
        check("areset_out", out, 0);
        check("areset_valid", valid, 0);
        tick();
        rst = 1'b0;
        tick();
        check("release_pend", pend, 16'hFFFF);
        req = '0;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        ready = 1'b1;
        wait_empty(100);
        tick();
        check("all16_pend", pend, 0);
        check("all16_valid", valid, 0);

        // Backpressure: code 2 held for 10 cycles, then 2 and 5 with a gap between
        do_reset();
        req = 16'h0024;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd5);
        tick();
        req = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", valid, 1);
            check("bp_out", out, 2);
        end
        ready = 1'b1;
        tick();
        check("bp_gap", valid, 0);
        tick();
        check("bp_second_valid", valid, 1);
        check("bp_second_out", out, 5);
        tick();
        check("bp_done", valid, 0);
        check("bp_pend", pend, 0);

        // Set-wins collision on code 3
        do_reset();
        req = 16'h0008;
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd3);
        tick();
        req = '0;
        tick();
        check("col_hold_out", out, 3);
        ready = 1'b1;
        req   = 16'h0008;
        tick();
        req = '0;
        check("col_pend3", pend[3], 1);
        check("col_valid_gap", valid, 0);
        wait_empty(20);
        tick();
        check("col_pend_end", pend, 0);

        // Continuous 0 and 15 requests: starvation (fixed) or alternation (round robin)
        do_reset();
        req   = 16'h8001;
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int c0;
`ifdef ROUND_ROBIN_EN
            exp_q.push_back((k % 2 == 0) ? 4'd0 : 4'd15);
`else
            exp_q.push_back(4'd0);
`endif
            c0 = xfer_cnt;
            for (int i = 0; i < 10 && xfer_cnt == c0; i++) @(posedge clk);
            #1;
            check("pair_xfer_seen", (xfer_cnt != c0), 1);
        end
        req   = '0;
        ready = 1'b0;
        check("pair_pend", pend, 16'h8001);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd15);
        ready = 1'b1;
        wait_empty(20);
        tick();
        check("pair_idle", valid, 0);
        check("pair_pend_end", pend, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
